// File: rtl/ldpc_seg_filler_packer.sv
// Segments a transport-block bit stream into LDPC code blocks of kb lifted columns.
// Columns past the code block's K' data bits are zero-filled (filler/PAD).
module ldpc_seg_filler_packer #(
  parameter int MAX_ZC = 384,
  parameter int IN_W   = 64,
  parameter int KB_MAX = 22
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic [8:0]        cfg_zc,
  input  logic [4:0]        cfg_kb,
  input  logic [13:0]       cfg_kprime,
  input  logic [5:0]        cfg_num_cb,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MAX_ZC-1:0] out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_col_idx,
  output logic [5:0]        out_cb_idx,
  output logic              out_last_col,
  output logic              out_last_cb,
  output logic              busy,
  output logic              cfg_err
);

  localparam int BUF_W = MAX_ZC + IN_W - 1;
  localparam int FW    = $clog2(MAX_ZC + IN_W);

  typedef enum logic [2:0] {IDLE, FILL, EMIT, PAD, DONE} state_e;

  state_e            state_q, state_d;
  logic [8:0]        zc_q, zc_d;
  logic [4:0]        kb_q, kb_d;
  logic [13:0]       kp_q, kp_d;
  logic [5:0]        ncb_q, ncb_d;
  logic [19:0]       bits_left_q, bits_left_d;
  logic [13:0]       cb_left_q, cb_left_d;
  logic [4:0]        col_q, col_d;
  logic [5:0]        cb_q, cb_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [MAX_ZC-1:0] out_col_q, out_col_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_col_idx_q, out_col_idx_d;
  logic [5:0]        out_cb_idx_q, out_cb_idx_d;
  logic              out_last_col_q, out_last_col_d;
  logic              out_last_cb_q, out_last_cb_d;
  logic              busy_q, busy_d;
  logic              cfg_err_q, cfg_err_d;

  logic [FW-1:0]     need, take;
  logic [13:0]       cb_left_nxt;
  logic [15:0]       kbzc;
  logic              cfg_ok, last_col, last_cb, in_hs;
  logic [MAX_ZC-1:0] col_data;
  logic [IN_W-1:0]   in_masked;

  assign kbzc   = 16'(cfg_kb) * 16'(cfg_zc);
  assign cfg_ok = (cfg_zc != '0) && (32'(cfg_zc) <= MAX_ZC) &&
                  (cfg_kb != '0) && (32'(cfg_kb) <= KB_MAX) &&
                  (cfg_kprime != '0) && (16'(cfg_kprime) <= kbzc) &&
                  (cfg_num_cb != '0);

  assign need        = (cb_left_q < 14'(zc_q)) ? FW'(cb_left_q) : FW'(zc_q);
  assign take        = (bits_left_q < 20'(IN_W)) ? FW'(bits_left_q) : FW'(IN_W);
  assign cb_left_nxt = cb_left_q - 14'(need);
  assign last_col    = (col_q == kb_q - 5'd1);
  assign last_cb     = (cb_q == ncb_q - 6'd1);
  assign in_ready    = (state_q == FILL) && (fill_q < need) && (bits_left_q != '0);
  assign in_hs       = in_valid && in_ready;

  // Only the first `need` bits belong to this column; the rest is carry-over or filler.
  always_comb begin
    col_data = '0;
    for (int i = 0; i < MAX_ZC; i++)
      if (i < int'(need)) col_data[i] = buf_q[i];
  end

  // Tail bits of the final word lie beyond C*K' and are dropped on entry.
  always_comb begin
    in_masked = '0;
    for (int i = 0; i < IN_W; i++)
      if (i < int'(take)) in_masked[i] = in_data[i];
  end

  always_comb begin
    state_d        = state_q;
    zc_d           = zc_q;
    kb_d           = kb_q;
    kp_d           = kp_q;
    ncb_d          = ncb_q;
    bits_left_d    = bits_left_q;
    cb_left_d      = cb_left_q;
    col_d          = col_q;
    cb_d           = cb_q;
    fill_d         = fill_q;
    buf_d          = buf_q;
    out_col_d      = out_col_q;
    out_valid_d    = out_valid_q;
    out_col_idx_d  = out_col_idx_q;
    out_cb_idx_d   = out_cb_idx_q;
    out_last_col_d = out_last_col_q;
    out_last_cb_d  = out_last_cb_q;
    busy_d         = busy_q;
    cfg_err_d      = 1'b0;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        if (cfg_ok) begin
          zc_d        = cfg_zc;
          kb_d        = cfg_kb;
          kp_d        = cfg_kprime;
          ncb_d       = cfg_num_cb;
          bits_left_d = 20'(cfg_num_cb) * 20'(cfg_kprime);
          cb_left_d   = cfg_kprime;
          col_d       = '0;
          cb_d        = '0;
          fill_d      = '0;
          buf_d       = '0;
          busy_d      = 1'b1;
          state_d     = FILL;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      FILL: begin
        if (need == '0)
          state_d = PAD;
        else if (fill_q >= need)
          state_d = EMIT;
        else if (in_hs) begin
          buf_d       = buf_q | (BUF_W'(in_masked) << fill_q);
          fill_d      = fill_q + take;
          bits_left_d = bits_left_q - 20'(take);
        end
      end
      EMIT, PAD: begin
        if (!out_valid_q) begin
          out_valid_d    = 1'b1;
          out_col_d      = (state_q == EMIT) ? col_data : '0;
          out_col_idx_d  = col_q;
          out_cb_idx_d   = cb_q;
          out_last_col_d = last_col;
          out_last_cb_d  = last_cb;
        end else if (out_ready) begin
          // need is zero in PAD, so the shift and fill update are no-ops there
          out_valid_d = 1'b0;
          buf_d       = buf_q >> need;
          fill_d      = fill_q - need;
          cb_left_d   = cb_left_nxt;
          if (last_col) begin
            col_d = '0;
            if (last_cb) begin
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              cb_d      = cb_q + 6'd1;
              cb_left_d = kp_q;
              state_d   = FILL;
            end
          end else begin
            col_d   = col_q + 5'd1;
            state_d = (cb_left_nxt == '0) ? PAD : FILL;
          end
        end
      end
      DONE: begin
        buf_d   = '0;
        fill_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      zc_q           <= '0;
      kb_q           <= '0;
      kp_q           <= '0;
      ncb_q          <= '0;
      bits_left_q    <= '0;
      cb_left_q      <= '0;
      col_q          <= '0;
      cb_q           <= '0;
      fill_q         <= '0;
      buf_q          <= '0;
      out_col_q      <= '0;
      out_valid_q    <= 1'b0;
      out_col_idx_q  <= '0;
      out_cb_idx_q   <= '0;
      out_last_col_q <= 1'b0;
      out_last_cb_q  <= 1'b0;
      busy_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      zc_q           <= zc_d;
      kb_q           <= kb_d;
      kp_q           <= kp_d;
      ncb_q          <= ncb_d;
      bits_left_q    <= bits_left_d;
      cb_left_q      <= cb_left_d;
      col_q          <= col_d;
      cb_q           <= cb_d;
      fill_q         <= fill_d;
      buf_q          <= buf_d;
      out_col_q      <= out_col_d;
      out_valid_q    <= out_valid_d;
      out_col_idx_q  <= out_col_idx_d;
      out_cb_idx_q   <= out_cb_idx_d;
      out_last_col_q <= out_last_col_d;
      out_last_cb_q  <= out_last_cb_d;
      busy_q         <= busy_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign out_col      = out_col_q;
  assign out_valid    = out_valid_q;
  assign out_col_idx  = out_col_idx_q;
  assign out_cb_idx   = out_cb_idx_q;
  assign out_last_col = out_last_col_q;
  assign out_last_cb  = out_last_cb_q;
  assign busy         = busy_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_ldpc_seg_filler_packer.sv
// Random-stimulus bench: columns are predicted directly from the bit stream by
// code-block/column arithmetic and compared at every output handshake.
module tb_ldpc_seg_filler_packer;
  localparam int MAX_ZC = 384;
  localparam int IN_W   = 64;
  localparam int KB_MAX = 22;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [8:0]        cfg_zc = '0;
  logic [4:0]        cfg_kb = '0;
  logic [13:0]       cfg_kprime = '0;
  logic [5:0]        cfg_num_cb = '0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [MAX_ZC-1:0] out_col;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4:0]        out_col_idx;
  logic [5:0]        out_cb_idx;
  logic              out_last_col, out_last_cb, busy, cfg_err;

  ldpc_seg_filler_packer #(.MAX_ZC(MAX_ZC), .IN_W(IN_W), .KB_MAX(KB_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_zc(cfg_zc),
    .cfg_kb(cfg_kb), .cfg_kprime(cfg_kprime), .cfg_num_cb(cfg_num_cb),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_col_idx(out_col_idx), .out_cb_idx(out_cb_idx),
    .out_last_col(out_last_col), .out_last_cb(out_last_cb),
    .busy(busy), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit bits_mem [0:131071];

  task automatic chk(input string tag, input logic [MAX_ZC-1:0] got, input logic [MAX_ZC-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Column col of code block cb holds message bits col*zc.. of that block, zero past K'.
  function automatic logic [MAX_ZC-1:0] exp_col(int zc, int kp, int cb, int col);
    logic [MAX_ZC-1:0] v;
    v = '0;
    for (int i = 0; i < zc; i++)
      if (col*zc + i < kp) v[i] = bits_mem[cb*kp + col*zc + i];
    return v;
  endfunction

  task automatic run_case(input int zc, input int kb, input int kp, input int nc, input bit rnd,
                          input int hold_col, input int rst_col, output int cycles);
    int nbits, nw, wi, cb, col, cyc, hold;
    bit done, aborted;
    logic [MAX_ZC-1:0] held;
    nbits = nc*kp; nw = (nbits + IN_W - 1) / IN_W;
    wi = 0; cb = 0; col = 0; cyc = 0; hold = 0; done = 0; aborted = 0; held = '0;
    for (int i = 0; i < nw*IN_W; i++) bits_mem[i] = 1'($urandom_range(0, 1));
    @(negedge clk);
    cfg_zc = 9'(zc); cfg_kb = 5'(kb); cfg_kprime = 14'(kp); cfg_num_cb = 6'(nc);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && cyc < 20000) begin
      in_valid = (wi < nw) && (!rnd || $urandom_range(0, 3) != 0);
      for (int b = 0; b < IN_W; b++) in_data[b] = (wi < nw) ? bits_mem[wi*IN_W + b] : 1'b0;
      if (rst_col >= 0 && out_valid && cb == 0 && col == rst_col) begin
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_idx", {out_col_idx, out_cb_idx, out_last_col, out_last_cb, cfg_err}, 0);
        done = 1; aborted = 1;
      end else begin
        if (hold_col >= 0 && out_valid && cb == 0 && col == hold_col && hold < 5) begin
          out_ready = 1'b0;
          if (hold == 0) held = out_col;
          else chk("hold_stable", out_col, held);
          chk("hold_in_ready", in_ready, 0);
          hold++;
        end else begin
          out_ready = !rnd || $urandom_range(0, 2) != 0;
        end
        if (in_valid && in_ready) wi++;
        if (out_valid && out_ready) begin
          chk($sformatf("cb%0d_col%0d_data", cb, col), out_col, exp_col(zc, kp, cb, col));
          chk($sformatf("cb%0d_col%0d_idx", cb, col), {out_cb_idx, out_col_idx}, {6'(cb), 5'(col)});
          chk($sformatf("cb%0d_col%0d_flags", cb, col), {out_last_cb, out_last_col},
              {cb == nc-1, col == kb-1});
          if (hold > 0 && col == hold_col && cb == 0) chk("hold_release", out_col, held);
          col++;
          if (col == kb) begin col = 0; cb++; if (cb == nc) done = 1; end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    cycles = cyc;
    if (aborted) begin
      @(negedge clk);
      reset_n = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk("post_rst_no_col", {out_valid, busy}, 0);
      end
      in_valid = 1'b0;
      cycles = -1;
    end else if (!done) begin
      chk("timeout", 0, 1);
    end else begin
      chk("busy_end", busy, 0);
      chk("words_used", 32'(wi), 32'(nw));
      chk("in_ready_end", in_ready, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  int c0, c1, tmp, zc, kb, kp, nc;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, busy, in_ready, cfg_err, out_last_col, out_last_cb}, 0);
    chk("reset_col", out_col, 0);
    reset_n = 1'b1;
    @(negedge clk);

    cfg_zc = 9'd400; cfg_kb = 5'd22; cfg_kprime = 14'd8448; cfg_num_cb = 6'd1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("cfg_err_pulse", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    chk("cfg_err_clear", {cfg_err, busy, out_valid}, 0);

    run_case(384, 22, 8448, 1, 0, -1, -1, c0);
    run_case(384, 22, 8448, 1, 0, 3, -1, c1);
    chk("backpressure_delay", 32'(c1), 32'(c0 + 5));
    run_case(52, 10, 500, 1, 1, -1, -1, tmp);
    run_case(64, 2, 100, 2, 1, -1, -1, tmp);
    run_case(16, 4, 20, 1, 0, -1, -1, tmp);
    run_case(16, 4, 20, 3, 1, -1, -1, tmp);
    run_case(384, 22, 8448, 1, 0, -1, 5, tmp);
    run_case(384, 22, 8448, 1, 0, -1, -1, c1);
    chk("fresh_run_cycles", 32'(c1), 32'(c0));

    for (int r = 0; r < 6; r++) begin
      zc = $urandom_range(1, MAX_ZC);
      kb = $urandom_range(1, KB_MAX);
      kp = (r % 2 == 0) ? $urandom_range(1, kb*zc) : $urandom_range(1, zc + 1);
      if (kp > kb*zc) kp = kb*zc;
      nc = $urandom_range(1, 3);
      run_case(zc, kb, kp, nc, 1, -1, -1, tmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ldpc_seg_filler_packer.md
LDPC_SEG_FILLER_PACKER -- requirements
Module: ldpc_seg_filler_packer

Interface
REQ-001 Parameter MAX_ZC, default 384: largest lifting size; width of out_col.
REQ-002 Parameter IN_W, default 64: input word width; IN_W in 1..MAX_ZC.
REQ-003 Parameter KB_MAX, default 22: largest number of message columns per code block.
REQ-004 clk  in  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 cfg_start  in  1  one-cycle pulse; samples cfg_* and starts a transport block.
REQ-007 cfg_zc  in  9  lifting size Zc.
REQ-008 cfg_kb  in  5  message columns per code block.
REQ-009 cfg_kprime  in  14  data bits per code block (K', CRC included).
REQ-010 cfg_num_cb  in  6  number of code blocks C.
REQ-011 in_data  in  IN_W  input bits; in_data[0] is the earliest bit.
REQ-012 in_valid / in_ready  in / out  1  input handshake.
REQ-013 out_col  out  MAX_ZC  one lifted column; bit 0 is the earliest bit.
REQ-014 out_valid / out_ready  out / in  1  output handshake.
REQ-015 out_col_idx  out  5  column index within the code block; out_cb_idx  out  6  code block index.
REQ-016 out_last_col  out  1  marks column kb-1; out_last_cb  out  1  marks code block C-1.
REQ-017 busy  out  1  high from an accepted cfg_start until the final column handshake.
REQ-018 cfg_err  out  1  one-cycle pulse on a rejected configuration.

Function
REQ-019 The block shall implement states IDLE, FILL, EMIT, PAD and DONE.
REQ-020 In IDLE, cfg_start shall be accepted only if 1<=zc<=MAX_ZC, 1<=kb<=KB_MAX, 1<=kprime<=kb*zc and num_cb>=1. An accepted start shall latch the configuration and enter FILL on the next cycle.
REQ-021 A rejected cfg_start shall pulse cfg_err for one cycle and leave the block in IDLE. cfg_start outside IDLE shall be ignored.
REQ-022 Staging buffer: MAX_ZC+IN_W-1 bits with a fill counter. Accepted words shall be appended LSB-first at position fill.
REQ-023 need = min(zc, data bits remaining in the current code block).
REQ-024 in_ready = (state==FILL) and (fill < need) and (input words remaining > 0).
REQ-025 Total input words = ceil(C*kprime/IN_W). Bits of the final word beyond C*kprime shall be discarded.
REQ-026 FILL->EMIT when fill >= need. out_valid shall rise the cycle after entering EMIT.
REQ-027 out_col[i] shall equal buffer[i] for i<need, and 0 for need<=i<MAX_ZC (filler bits, and bits above zc).
REQ-028 On the out_valid && out_ready handshake, the buffer shall shift down by need and fill -= need. Carry-over bits belong to the next column or next code block.
REQ-029 Once a code block's kprime data bits are exhausted and columns remain, the state shall be PAD. PAD emits all-zero columns without consuming input.
REQ-030 After column kb-1 of code block C-1 is handshaken, the block shall enter DONE. DONE->IDLE the next cycle, with busy=0 and the buffer cleared.
REQ-031 While out_valid=1 and out_ready=0, out_col, the index outputs and the flags shall remain stable. in_ready shall be 0.
REQ-032 Simultaneous in handshake and out handshake cannot occur, because the EMIT state excludes in_ready. Throughput is one column per handshake plus the fill cycles.
REQ-033 Index widths: kb*zc needs 14 bits and C*kprime needs 20 bits. All counters shall be sized so they never wrap.

Reset
REQ-034 On reset_n=0, the block shall go to IDLE. out_col, out_valid, in_ready, busy, cfg_err, all indices, the flags, fill and the buffer shall be 0.
REQ-035 A reset mid-block shall abandon the block. No column shall be emitted after release until a new cfg_start.

Verification
REQ-036 zc=384, kb=22, kprime=8448, C=1, IN_W=64, 132 words:
- 22 columns, equal to bits 384n..384n+383.
- out_last_col on column 21.
REQ-037 zc=52, kb=10, kprime=500, C=1, 8 words:
- Columns 0-8 carry full data.
- Column 9 carries bits 468-499 in [31:0]; bits [383:32] are 0.
- Input bits 500-511 are discarded.
REQ-038 zc=64, kb=2, kprime=100, C=2, 4 words:
- CB0 col1 carries bits 64-99, then zeros.
- CB1 col0 carries bits 100-163 (straddles words 1-2).
- out_last_cb is set with CB1 col1.
REQ-039 zc=16, kb=4, kprime=20, C=1:
- Columns 2 and 3 are emitted from PAD as all zeros.
- No extra input word is requested.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles on column 3 of REQ-036.
- out_col stays stable.
- in_ready stays 0.
- Completion is delayed by exactly 5 cycles.
REQ-041 Configuration and reset checks:
- cfg_zc=400 gives a cfg_err pulse with busy staying 0.
- Asserting reset_n=0 during column 5 gives all outputs 0, and a fresh run then matches REQ-036.
